reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- General-purpose register file for the simple processor datapath: eight 8-bit registers, one synchronous write port and two combinational read ports.
- The write side captures data on the rising clock edge, like a D flip-flop.
- This block adds the read side, which the ALU operand path consumes.
- It tracks which registers have been written since reset, so the control unit can detect reads of uninitialised registers.

Parameters:
- DATA_W, 8, width of each register and of the data ports.
- ADDR_W, 3, width of each register address; depth = 2**ADDR_W (8).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- write_en  input  1  write strobe, sampled at posedge clk.
- write_addr  input  ADDR_W  destination register index.
- write_data  input  DATA_W  data to write.
- read_addr1  input  ADDR_W  operand-1 register index.
- read_addr2  input  ADDR_W  operand-2 register index.
- read_data1  output  DATA_W  contents of register read_addr1.
- read_data2  output  DATA_W  contents of register read_addr2.
- read_valid1  output  1  register read_addr1 has been written since reset.
- read_valid2  output  1  register read_addr2 has been written since reset.
- write_count  output  8  number of accepted writes since reset; saturates at 255.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0.
  - All written flags clear to 0.
  - write_count clears to 0.
  - Consequently read_data1/2 = 0 and read_valid1/2 = 0 while reset is held.
- Reset asserted mid-cycle takes effect immediately, without waiting for clk.
- A write_en pulse coincident with reset assertion is discarded.
- Reset release is synchronised by the surrounding system. The block requires only that rst_n is not released within setup/hold of a clk edge.
- Write, on posedge clk with rst_n high and write_en = 1:
  - reg[write_addr] <= write_data.
  - written[write_addr] <= 1.
  - write_count increments by 1 unless it is 255.
- write_en = 0: no state change.
- All register indices, including 0, are writable; there is no hard-wired zero register.
- Read, combinational:
  - read_dataN = reg[read_addrN] and read_validN = written[read_addrN].
  - Outputs change within the same cycle as the address changes; zero-cycle read latency.
- Read-during-write, same address, without the optional feature:
  - The read port returns the OLD value until the clock edge and the new value after it. Write-to-read latency is 1 cycle.
  - read_validN follows the same timing.
- Both read ports may address the same register simultaneously; both return identical data.
- Overwriting a register replaces its data. Its written flag stays 1.
- write_count saturation:
  - At 255, further writes still update registers and flags, but the count holds at 255.
  - Writes of identical data to the same address each count.
- X or Z on write_addr while write_en = 1 is a caller error; behaviour is unspecified.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- When defined: if write_en = 1 and read_addrN == write_addr in the same cycle, read_dataN = write_data and read_validN = 1 combinationally, before the edge. This removes the 1-cycle write-to-read hazard for back-to-back dependent instructions.
- When not defined: no forwarding path; behaviour is exactly the read-during-write rule above.
- Register and flag update timing is identical in both builds.

Test Plan:
- Reset check: hold rst_n = 0 for 2 cycles, sweep read_addr1/2 over 0..7 -> read_data1/2 = 0x00, read_valid1/2 = 0, write_count = 0.
- Basic write/read: write 0x5A to reg 3, then 0xC3 to reg 7; set read_addr1 = 3, read_addr2 = 7 -> read_data1 = 0x5A, read_data2 = 0xC3, both valid = 1, write_count = 2. Reading reg 4 -> data 0x00, valid 0.
- Read-during-write: reg 2 holds 0x11; write 0x22 to reg 2 with read_addr1 = 2.
  - Bypass off: read_data1 = 0x11 before the edge, 0x22 after.
  - Bypass on: read_data1 = 0x22 in the same cycle.
- Asynchronous reset mid-operation: write 0xFF to reg 5, then pull rst_n low between clock edges -> read_data1 (addr 5) = 0x00 and valid = 0 immediately, without a clock edge. A write_en issued during reset is not applied.
- Saturation: perform 260 writes cycling over addresses 0..7 -> write_count = 255 and holds; the last write's data is still readable at its address.
- Dual-port same address: write 0x7E to reg 0; read_addr1 = read_addr2 = 0 -> both read_data = 0x7E, both valid = 1.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Eight-entry register file: one synchronous write port, two combinational read ports,
// per-register written flags and a saturating write counter. Optional write-to-read
// forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_2r1w #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_valid1,
    output logic              read_valid2,
    output logic [7:0]        write_count
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q;
    logic [7:0]        count_q;
    logic [7:0]        count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (write_en && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // NOTE: the storage array is reset because uninitialised registers must read as zero;
    // this costs a reset net per bit, which is why larger RAMs are usually left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q <= '0;
            count_q   <= '0;
        end else begin
            count_q <= count_d;
            if (write_en) begin
                mem_q[write_addr]     <= write_data;
                written_q[write_addr] <= 1'b1;
            end
        end
    end

    // Forwarding is gated by rst_n so the outputs stay zero while reset is held.
    always_comb begin
        read_data1  = mem_q[read_addr1];
        read_valid1 = written_q[read_addr1];
        read_data2  = mem_q[read_addr2];
        read_valid2 = written_q[read_addr2];
        if (BYPASS && rst_n && write_en) begin
            if (read_addr1 == write_addr) begin
                read_data1  = write_data;
                read_valid1 = 1'b1;
            end
            if (read_addr2 == write_addr) begin
                read_data2  = write_data;
                read_valid2 = 1'b1;
            end
        end
    end

    assign write_count = count_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed vector table, hand-written corner
// sequences, and randomized traffic compared against an array-based reference model.
module tb_reg_file_2r1w;

    logic       clk;
    logic       rst_n;
    logic       write_en;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic [2:0] read_addr1;
    logic [2:0] read_addr2;
    logic [7:0] read_data1;
    logic [7:0] read_data2;
    logic       read_valid1;
    logic       read_valid2;
    logic [7:0] write_count;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file_2r1w #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_addr1  (read_addr1),
        .read_addr2  (read_addr2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .read_valid1 (read_valid1),
        .read_valid2 (read_valid2),
        .write_count (write_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays plus an integer write counter.
    logic [7:0] m_mem [8];
    bit         m_wr  [8];
    int         m_cnt;

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [7:0] exp_d1;
        logic [7:0] exp_d2;
        logic       exp_v1;
        logic       exp_v2;
        logic [7:0] exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_mem[i] = 8'h00;
            m_wr[i]  = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [7:0] d);
        m_mem[a] = d;
        m_wr[a]  = 1'b1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        model_write(a, d);
        write_en = 1'b0;
    endtask

    function automatic logic [8:0] model_read(input logic [2:0] ra, input logic we,
                                              input logic [2:0] wa, input logic [7:0] wd);
        if (BYPASS && we && (ra == wa)) return {1'b1, wd};
        return {m_wr[ra], m_mem[ra]};
    endfunction

    vec_t vecs [6];

    initial begin
        rst_n      = 1'b0;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        read_addr1 = '0;
        read_addr2 = '0;
        model_reset();

        // Reset held: every address reads zero and invalid.
        repeat (2) tick();
        for (int a = 0; a < 8; a++) begin
            read_addr1 = 3'(a);
            read_addr2 = 3'(7 - a);
            #1;
            check("reset_rd", {read_data1, read_data2, 6'b0, read_valid1, read_valid2}, 32'h0);
        end
        check("reset_cnt", write_count, 32'd0);
        rst_n = 1'b1;
        tick();

        vecs[0] = '{1'b1, 3'd3, 8'h5A, 3'd3, 3'd7, 8'h5A, 8'h00, 1'b1, 1'b0, 8'd1};
        vecs[1] = '{1'b1, 3'd7, 8'hC3, 3'd3, 3'd7, 8'h5A, 8'hC3, 1'b1, 1'b1, 8'd2};
        vecs[2] = '{1'b0, 3'd4, 8'hEE, 3'd4, 3'd3, 8'h00, 8'h5A, 1'b0, 1'b1, 8'd2};
        vecs[3] = '{1'b1, 3'd0, 8'h7E, 3'd0, 3'd0, 8'h7E, 8'h7E, 1'b1, 1'b1, 8'd3};
        vecs[4] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd0, 8'hA5, 8'h7E, 1'b1, 1'b1, 8'd4};
        vecs[5] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd7, 8'hA5, 8'hC3, 1'b1, 1'b1, 8'd5};

        foreach (vecs[i]) begin
            write_en   = vecs[i].we;
            write_addr = vecs[i].wa;
            write_data = vecs[i].wd;
            read_addr1 = vecs[i].ra1;
            read_addr2 = vecs[i].ra2;
            tick();
            if (vecs[i].we) model_write(vecs[i].wa, vecs[i].wd);
            write_en = 1'b0;
            #1;
            check($sformatf("vec%0d_d1", i), read_data1, vecs[i].exp_d1);
            check($sformatf("vec%0d_d2", i), read_data2, vecs[i].exp_d2);
            check($sformatf("vec%0d_v", i), {read_valid1, read_valid2},
                  {vecs[i].exp_v1, vecs[i].exp_v2});
            check($sformatf("vec%0d_cnt", i), write_count, vecs[i].exp_cnt);
        end

        // Read-during-write on a written register (2) and an unwritten one (6).
        do_write(3'd2, 8'h11);
        read_addr1 = 3'd2;
        read_addr2 = 3'd6;
        write_en   = 1'b1;
        write_addr = 3'd2;
        write_data = 8'h22;
        #1;
        check("rdw_pre_d1", read_data1, BYPASS ? 32'h22 : 32'h11);
        check("rdw_pre_v1", read_valid1, 32'd1);
        tick();
        model_write(3'd2, 8'h22);
        write_addr = 3'd6;
        write_data = 8'h66;
        #1;
        check("rdw_post_d1", read_data1, 32'h22);
        check("rdw_pre_d2", read_data2, BYPASS ? 32'h66 : 32'h00);
        check("rdw_pre_v2", read_valid2, BYPASS ? 32'd1 : 32'd0);
        tick();
        model_write(3'd6, 8'h66);
        write_en = 1'b0;
        #1;
        check("rdw_post_d2", {read_valid2, read_data2}, {1'b1, 8'h66});

        // Randomized traffic against the model, checked before each edge.
        for (int n = 0; n < 300; n++) begin
            logic [8:0] e1, e2;
            write_en   = 1'($urandom_range(0, 1));
            write_addr = 3'($urandom_range(0, 7));
            write_data = 8'($urandom);
            read_addr1 = 3'($urandom_range(0, 7));
            read_addr2 = (n % 5 == 0) ? write_addr : 3'($urandom_range(0, 7));
            #1;
            e1 = model_read(read_addr1, write_en, write_addr, write_data);
            e2 = model_read(read_addr2, write_en, write_addr, write_data);
            check("rand_p1", {read_valid1, read_data1}, e1);
            check("rand_p2", {read_valid2, read_data2}, e2);
            check("rand_cnt", write_count, m_cnt);
            tick();
            if (write_en) model_write(write_addr, write_data);
            write_en = 1'b0;
        end

        // Saturation: 260 more writes cycling over every address.
        for (int i = 0; i < 260; i++) begin
            do_write(3'(i % 8), 8'(i));
        end
        read_addr1 = 3'd3;
        #1;
        check("sat_cnt", write_count, 32'd255);
        check("sat_last", {read_valid1, read_data1}, {1'b1, 8'h03});
        check("sat_model", read_data1, m_mem[3]);
        do_write(3'd4, 8'h44);
        read_addr2 = 3'd4;
        #1;
        check("sat_hold", write_count, 32'd255);
        check("sat_data", read_data2, 32'h44);

        // Asynchronous reset mid-cycle, with a write attempted while it is held.
        do_write(3'd5, 8'hFF);
        read_addr1 = 3'd5;
        #1;
        check("pre_rst_d", {read_valid1, read_data1}, {1'b1, 8'hFF});
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_d", {read_valid1, read_data1}, 32'h0);
        check("async_rst_cnt", write_count, 32'd0);
        write_en   = 1'b1;
        write_addr = 3'd5;
        write_data = 8'hAB;
        read_addr2 = 3'd5;
        #1;
        check("rst_wr_comb", {read_valid2, read_data2}, 32'h0);
        tick();
        write_en = 1'b0;
        #1;
        check("rst_wr_drop", {read_valid1, read_data1}, 32'h0);
        check("rst_wr_cnt", write_count, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_d", {read_valid1, read_data1}, 32'h0);
        do_write(3'd5, 8'h3C);
        #1;
        check("post_rst_wr", {read_valid1, read_data1, write_count}, {1'b1, 8'h3C, 8'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
